// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer for an RV32I-style datapath.
// It walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// gives each memory request a fixed number of cycles to complete, and stops
// in HALT on an illegal opcode or a bus timeout.
module multicycle_sequencer #(
    parameter int TIMEOUT     = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             opcode,
    input  logic                   imemReady,
    input  logic                   dmemReady,
    output logic                   imemRequest,
    output logic                   irWrite,
    output logic                   dmemRequest,
    output logic                   readMemory,
    output logic                   writeMemory,
    output logic                   writeRegister,
    output logic                   pcUpdate,
    output logic [2:0]             state,
    output logic                   halted,
    output logic                   busError,
    output logic [COUNT_WIDTH-1:0] instretCount
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The wait counter only has to reach TIMEOUT-1; at that value the
    // sequencer either proceeds or halts, so it never counts further.
    localparam int              WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

    state_e                   state_q, state_d;
    logic [6:0]               opcode_q, opcode_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic                     bus_err_q, bus_err_d;
    logic [COUNT_WIDTH-1:0]   count_q;

    logic imem_req, ir_wr, dmem_req, rd_mem, wr_mem, wr_reg, pc_upd, retire;
    logic is_load, is_store;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    assign is_load  = (opcode_q == OP_LOAD);
    assign is_store = (opcode_q == OP_STORE);

    // Next-state, wait-counter and enable decode for the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        opcode_d  = opcode_q;
        wait_d    = wait_q;
        bus_err_d = bus_err_q;
        imem_req  = 1'b0;
        ir_wr     = 1'b0;
        dmem_req  = 1'b0;
        rd_mem    = 1'b0;
        wr_mem    = 1'b0;
        wr_reg    = 1'b0;
        pc_upd    = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imemReady) begin
                    ir_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                // The decision uses the live opcode; later states see only the latched copy.
                opcode_d = opcode;
                state_d  = is_legal(opcode) ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else if (opcode_q == OP_BRANCH) begin
                    pc_upd  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                rd_mem   = is_load;
                wr_mem   = is_store;
                if (dmemReady) begin
                    if (is_load) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_upd  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                wr_reg  = 1'b1;
                pc_upd  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // State, latched opcode, wait counter, error flag and retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from values sampled before the edge, independent of statement order.
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            if (retire) count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    // Reset forces the enables low combinationally so they drop the moment
    // reset asserts, not on the following edge.
    assign imemRequest   = reset & imem_req;
    assign irWrite       = reset & ir_wr;
    assign dmemRequest   = reset & dmem_req;
    assign readMemory    = reset & rd_mem;
    assign writeMemory   = reset & wr_mem;
    assign writeRegister = reset & wr_reg;
    assign pcUpdate      = reset & pc_upd;

    assign state        = state_q;
    assign halted       = (state_q == S_HALT);
    assign busError     = bus_err_q;
    assign instretCount = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. Stimulus pushes the hand-computed
// per-cycle expectation into a queue; a monitor on the falling edge pops and
// compares it against the DUT outputs.
module tb_multicycle_sequencer;

    localparam int CW = 3;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] BAD  = 7'b1111111;

    // Enable vector order: imemRequest irWrite dmemRequest readMemory writeMemory writeRegister pcUpdate
    localparam logic [6:0] E0    = 7'b0000000;
    localparam logic [6:0] IREQ  = 7'b1000000;
    localparam logic [6:0] IRW   = 7'b0100000;
    localparam logic [6:0] DREQ  = 7'b0010000;
    localparam logic [6:0] RD    = 7'b0001000;
    localparam logic [6:0] WR    = 7'b0000100;
    localparam logic [6:0] WREG  = 7'b0000010;
    localparam logic [6:0] PC    = 7'b0000001;
    localparam logic [6:0] FETCH_OK = IREQ | IRW;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          imemReady, dmemReady;
    logic          imemRequest, irWrite, dmemRequest, readMemory, writeMemory;
    logic          writeRegister, pcUpdate, halted, busError;
    logic [2:0]    state;
    logic [CW-1:0] instretCount;

    typedef struct {
        string         name;
        logic [2:0]    st;
        logic [6:0]    en;
        logic          h;
        logic          be;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    multicycle_sequencer #(.TIMEOUT(16), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .imemReady    (imemReady),
        .dmemReady    (dmemReady),
        .imemRequest  (imemRequest),
        .irWrite      (irWrite),
        .dmemRequest  (dmemRequest),
        .readMemory   (readMemory),
        .writeMemory  (writeMemory),
        .writeRegister(writeRegister),
        .pcUpdate     (pcUpdate),
        .state        (state),
        .halted       (halted),
        .busError     (busError),
        .instretCount (instretCount)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] act_en;
            e = exp_q.pop_front();
            act_en = {imemRequest, irWrite, dmemRequest, readMemory, writeMemory,
                      writeRegister, pcUpdate};
            tests++;
            if ({state, act_en, halted, busError, instretCount} !==
                {e.st, e.en, e.h, e.be, e.cnt}) begin
                failed++;
                $display("FAIL %s: got state=%0d en=%b halted=%b busError=%b count=%0d, want state=%0d en=%b halted=%b busError=%b count=%0d",
                         e.name, state, act_en, halted, busError, instretCount,
                         e.st, e.en, e.h, e.be, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic step(input string name, input logic r, input logic [6:0] op,
                        input logic im, input logic dm, input logic [2:0] st,
                        input logic [6:0] en, input logic h, input logic be, input int cnt);
        exp_t e;
        reset     = r;
        opcode    = op;
        imemReady = im;
        dmemReady = dm;
        e.name = name;
        e.st   = st;
        e.en   = en;
        e.h    = h;
        e.be   = be;
        e.cnt  = CW'(cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A four-cycle zero-wait instruction through WRITEBACK.
    task automatic wb_instr(input string name, input logic [6:0] op, input int cnt);
        step({name, "_f"}, 1, op, 1, 1, 3'd0, FETCH_OK, 0, 0, cnt);
        step({name, "_d"}, 1, op, 1, 1, 3'd1, E0, 0, 0, cnt);
        step({name, "_e"}, 1, op, 1, 1, 3'd2, E0, 0, 0, cnt);
        step({name, "_w"}, 1, op, 1, 1, 3'd4, WREG | PC, 0, 0, cnt);
    endtask

    initial begin
        reset = 1'b0; opcode = ADD; imemReady = 1'b0; dmemReady = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: FETCH with every enable low.
        step("rst_a", 0, ADD, 1, 1, 3'd0, E0, 0, 0, 0);
        step("rst_b", 0, ADD, 1, 1, 3'd0, E0, 0, 0, 0);

        // ADD, zero-wait: states 0,1,2,4 then FETCH with count 1.
        wb_instr("add", ADD, 0);

        // LW with dmemReady arriving in the fourth MEMORY cycle.
        step("lw_f",  1, LW, 1, 0, 3'd0, FETCH_OK, 0, 0, 1);
        step("lw_d",  1, LW, 1, 0, 3'd1, E0, 0, 0, 1);
        step("lw_e",  1, LW, 1, 0, 3'd2, E0, 0, 0, 1);
        step("lw_m1", 1, LW, 1, 0, 3'd3, DREQ | RD, 0, 0, 1);
        step("lw_m2", 1, LW, 1, 0, 3'd3, DREQ | RD, 0, 0, 1);
        step("lw_m3", 1, LW, 1, 0, 3'd3, DREQ | RD, 0, 0, 1);
        step("lw_m4", 1, LW, 1, 1, 3'd3, DREQ | RD, 0, 0, 1);
        step("lw_w",  1, LW, 1, 1, 3'd4, WREG | PC, 0, 0, 1);

        // BEQ then SW, zero-wait.
        step("beq_f", 1, BEQ, 1, 1, 3'd0, FETCH_OK, 0, 0, 2);
        step("beq_d", 1, BEQ, 1, 1, 3'd1, E0, 0, 0, 2);
        step("beq_e", 1, BEQ, 1, 1, 3'd2, PC, 0, 0, 2);
        step("sw_f",  1, SW,  1, 1, 3'd0, FETCH_OK, 0, 0, 3);
        step("sw_d",  1, SW,  1, 1, 3'd1, E0, 0, 0, 3);
        step("sw_e",  1, SW,  1, 1, 3'd2, E0, 0, 0, 3);
        step("sw_m",  1, SW,  1, 1, 3'd3, DREQ | WR | PC, 0, 0, 3);

        // Fill the 3-bit counter to all ones and wrap it.
        wb_instr("jal", JAL, 4);
        step("lui_f1", 1, LUI, 0, 1, 3'd0, IREQ, 0, 0, 5);
        step("lui_f2", 1, LUI, 0, 1, 3'd0, IREQ, 0, 0, 5);
        wb_instr("lui", LUI, 5);
        wb_instr("auipc", AUI, 6);
        wb_instr("jalr", JALR, 7);

        // Fetch timeout: 16 cycles without imemReady, then HALT with busError.
        for (int i = 1; i <= 16; i++)
            step($sformatf("to_f%0d", i), 1, ADDI, 0, 0, 3'd0, IREQ, 0, 0, 0);
        step("to_halt1", 1, ADDI, 0, 0, 3'd5, E0, 1, 1, 0);
        step("to_halt2", 1, ADDI, 1, 1, 3'd5, E0, 1, 1, 0);

        // Reset leaves HALT; ready arrives on the 16th cycle, then illegal opcode.
        step("rst2", 0, BAD, 0, 0, 3'd0, E0, 0, 0, 0);
        for (int i = 1; i <= 15; i++)
            step($sformatf("late_f%0d", i), 1, BAD, 0, 0, 3'd0, IREQ, 0, 0, 0);
        step("late_f16", 1, BAD, 1, 0, 3'd0, FETCH_OK, 0, 0, 0);
        step("bad_d",    1, BAD, 1, 0, 3'd1, E0, 0, 0, 0);
        step("bad_halt1", 1, BAD, 1, 1, 3'd5, E0, 1, 0, 0);
        step("bad_halt2", 1, ADD, 1, 1, 3'd5, E0, 1, 0, 0);

        // Reset pulse, one branch, then reset in the middle of a load.
        step("rst3", 0, BEQ, 1, 1, 3'd0, E0, 0, 0, 0);
        step("b2_f", 1, BEQ, 1, 1, 3'd0, FETCH_OK, 0, 0, 0);
        step("b2_d", 1, BEQ, 1, 1, 3'd1, E0, 0, 0, 0);
        step("b2_e", 1, BEQ, 1, 1, 3'd2, PC, 0, 0, 0);
        step("lw2_f", 1, LW, 1, 0, 3'd0, FETCH_OK, 0, 0, 1);
        step("lw2_d", 1, LW, 1, 0, 3'd1, E0, 0, 0, 1);
        step("lw2_e", 1, LW, 1, 0, 3'd2, E0, 0, 0, 1);
        step("lw2_m", 1, LW, 1, 0, 3'd3, DREQ | RD, 0, 0, 1);
        step("rst_mid_mem", 0, LW, 1, 1, 3'd0, E0, 0, 0, 0);
        wb_instr("add2", ADD, 0);
        step("add2_next", 1, ADD, 0, 0, 3'd0, IREQ, 0, 0, 1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
